// File: rtl/z_exec_ctrl_if.sv
// Bus bundle between the execution controller and its memory, register file and ALU.
// The controller side uses the master modport; the environment uses slave.
interface z_exec_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] alu_ins;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        alu_zero;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output rf_we, rf_waddr, rf_wdata,
        output alu_ins, alu_a, alu_b, alu_shamt,
        input  alu_out, alu_zero
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  rf_we, rf_waddr, rf_wdata,
        input  alu_ins, alu_a, alu_b, alu_shamt,
        output alu_out, alu_zero
    );
endinterface

// File: rtl/z_exec_ctrl.sv
// Multi-cycle MIPS-subset controller: fetch, decode, execute via external ALU,
// memory access and register write-back. Owns PC, branches and load/store sequencing.
module z_exec_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    z_exec_ctrl_if.master       bus,
    output logic [31:0]         pc,
    output logic                halt
);
    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpAddiu   = 6'b001001;
    localparam logic [5:0] OpAndi    = 6'b001100;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] OpLw      = 6'b100011;
    localparam logic [5:0] OpSw      = 6'b101011;
    localparam logic [31:0] InsAddu  = 32'h0000_0021;
    localparam logic [31:0] InsSubu  = 32'h0000_0023;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] mdr_q, mdr_d;

    logic [5:0]  op, funct;
    logic [31:0] imm_se, imm_ze, br_off;
    logic        is_rtype, is_addiu, is_andi, is_beq, is_bne, is_lw, is_sw;
    logic        legal, taken;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign imm_se   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_ze   = {16'h0000, ir_q[15:0]};
    assign br_off   = {imm_se[29:0], 2'b00};
    assign is_rtype = (op == OpSpecial);
    assign is_addiu = (op == OpAddiu);
    assign is_andi  = (op == OpAndi);
    assign is_beq   = (op == OpBeq);
    assign is_bne   = (op == OpBne);
    assign is_lw    = (op == OpLw);
    assign is_sw    = (op == OpSw);

    assign pc   = pc_q;
    assign halt = (state_q == StHalt);

    always_comb begin
        legal = 1'b0;
        case (op)
            OpSpecial: legal = funct inside {6'b100001, 6'b100011, 6'b101111, 6'b000000, 6'b000010};
            OpAddiu, OpAndi, OpBeq, OpBne, OpLw, OpSw: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        taken    = 1'b0;

        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.rf_raddr1 = ir_q[25:21];
        bus.rf_raddr2 = ir_q[20:16];
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = is_rtype ? ir_q[15:11] : ir_q[20:16];
        bus.rf_wdata  = is_lw ? mdr_q : aluout_q;
        bus.alu_ins   = 32'h0;
        bus.alu_a     = 32'h0;
        bus.alu_b     = 32'h0;
        bus.alu_shamt = 5'h0;

        case (state_q)
            StFetch: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc_q;
                if (bus.mem_ack) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = bus.rf_rdata1;
                b_d     = bus.rf_rdata2;
                state_d = legal ? StExec : StHalt;
            end
            StExec: begin
                if (is_rtype) begin
                    bus.alu_ins   = ir_q;
                    bus.alu_a     = a_q;
                    bus.alu_b     = b_q;
                    bus.alu_shamt = ir_q[10:6];
                    aluout_d      = bus.alu_out;
                    state_d       = StWb;
                end else if (is_andi) begin
                    aluout_d = a_q & imm_ze;
                    state_d  = StWb;
                end else if (is_beq || is_bne) begin
                    bus.alu_ins = InsSubu;
                    bus.alu_a   = a_q;
                    bus.alu_b   = b_q;
                    // Zero is tested locally rather than trusting alu_zero.
                    taken       = is_beq ? (bus.alu_out == 32'h0) : (bus.alu_out != 32'h0);
                    if (taken) begin
                        pc_d = pc_q + br_off;
                    end
                    state_d = StFetch;
                end else begin
                    bus.alu_ins = InsAddu;
                    bus.alu_a   = a_q;
                    bus.alu_b   = imm_se;
                    aluout_d    = bus.alu_out;
                    if (is_addiu) begin
                        state_d = StWb;
                    end else if (ALIGN_CHECK && (bus.alu_out[1:0] != 2'b00)) begin
                        state_d = StHalt;
                    end else begin
                        state_d = StMem;
                    end
                end
            end
            StMem: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = is_sw;
                bus.mem_addr  = aluout_q;
                bus.mem_wdata = b_q;
                if (bus.mem_ack) begin
                    if (is_lw) begin
                        mdr_d   = bus.mem_rdata;
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                bus.rf_we = (bus.rf_waddr != 5'd0);
                state_d   = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase

        // Strobes must drop the moment reset asserts, even though the reset state is fetch.
        if (!rst_n) begin
            bus.mem_req = 1'b0;
            bus.mem_we  = 1'b0;
            bus.rf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            aluout_q <= 32'h0;
            mdr_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end
endmodule

// File: tb/tb_z_exec_ctrl.sv
// Random-program bench: an instruction-level model predicts every memory transfer and
// register write; a monitor compares them as the controller presents them.
module tb_z_exec_ctrl;
    localparam logic [31:0] ResetPc = 32'h0000_0100;
    localparam int          BaseIdx = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        halt;

    always #5 clk = ~clk;

    z_exec_ctrl_if bus ();

    z_exec_ctrl #(
        .RESET_PC    (ResetPc),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pc    (pc),
        .halt  (halt)
    );

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic [31:0] mem [1024];
    logic [31:0] rf [32];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rf [32];
    ev_t         exp_q [$];
    logic [31:0] exp_end_pc;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wait_left = 0;
    int          max_wait = 3;
    bit          stall = 1'b0;

    function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (fn)
            6'h21:   return a + b;
            6'h23:   return a - b;
            6'h2F:   return ~(a | b);
            6'h00:   return b << sh;
            6'h02:   return b >> sh;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.alu_out   = alu_f(bus.alu_ins[5:0], bus.alu_a, bus.alu_b, bus.alu_shamt);
    assign bus.alu_zero  = (bus.alu_out == 32'h0);
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input bit is_mem, input bit we, input logic [31:0] addr,
                                    input logic [31:0] data);
        ev_t e;
        e.is_mem = is_mem;
        e.we     = we;
        e.addr   = addr;
        e.data   = data;
        exp_q.push_back(e);
    endfunction

    function automatic void ref_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) begin
            push_ev(1'b0, 1'b1, {27'b0, r}, v);
            ref_rf[r] = v;
        end
    endfunction

    // Instruction-level model: runs the whole program and queues the expected bus activity.
    task automatic run_ref();
        logic [31:0] p, ins, a, b, se, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        bit          stop;
        p    = ResetPc;
        stop = 1'b0;
        for (int guard = 0; guard < 1000 && !stop; guard++) begin
            ins = ref_mem[p[11:2]];
            push_ev(1'b1, 1'b0, p, 32'h0);
            p  = p + 4;
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
            rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
            a  = ref_rf[rs]; b = ref_rf[rt];
            se = {{16{ins[15]}}, ins[15:0]};
            ea = a + se;
            case (op)
                6'h00: if (fn inside {6'h21, 6'h23, 6'h2F, 6'h00, 6'h02}) ref_wr(rd, alu_f(fn, a, b, sh));
                       else stop = 1'b1;
                6'h09: ref_wr(rt, a + se);
                6'h0C: ref_wr(rt, a & {16'h0, ins[15:0]});
                6'h04: if (a == b) p = p + (se << 2);
                6'h05: if (a != b) p = p + (se << 2);
                6'h23: if (ea[1:0] != 2'b00) stop = 1'b1;
                       else begin
                           push_ev(1'b1, 1'b0, ea, 32'h0);
                           ref_wr(rt, ref_mem[ea[11:2]]);
                       end
                6'h2B: if (ea[1:0] != 2'b00) stop = 1'b1;
                       else begin
                           push_ev(1'b1, 1'b1, ea, b);
                           ref_mem[ea[11:2]] = b;
                       end
                default: stop = 1'b1;
            endcase
        end
        exp_end_pc = p;
    endtask

    function automatic logic [4:0] pick_dest();
        logic [4:0] r;
        r = 5'($urandom_range(0, 6));
        if (r >= 5'd4) r = r + 5'd1;
        return r;
    endfunction

    // $4 is reserved as the data base pointer (0x800); branches only go forward.
    task automatic load_program(input int n, input bit bad_funct);
        logic [31:0] ins;
        logic [5:0]  fn;
        logic [4:0]  rs, rt;
        int          k, off;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 7);
            rs = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: fn = 6'h21;
                1: fn = 6'h23;
                2: fn = 6'h2F;
                3: fn = 6'h00;
                default: fn = 6'h02;
            endcase
            case (k)
                0, 1: ins = {6'h00, rs, 5'($urandom_range(0, 7)), pick_dest(),
                             5'($urandom_range(0, 31)), fn};
                2: ins = {6'h09, rs, pick_dest(), 16'($urandom)};
                3: ins = {6'h0C, rs, pick_dest(), 16'($urandom)};
                4, 5: begin
                    rt  = ($urandom_range(0, 1) == 1) ? rs : 5'($urandom_range(0, 7));
                    off = $urandom_range(0, 3);
                    if (i + 1 + off > n) off = n - 1 - i;
                    ins = {(k == 4) ? 6'h04 : 6'h05, rs, rt, 16'(off)};
                end
                6: ins = {6'h23, 5'd4, pick_dest(), 16'($urandom_range(0, 63) * 4)};
                default: ins = {6'h2B, 5'd4, 5'($urandom_range(0, 7)),
                                16'($urandom_range(0, 63) * 4)};
            endcase
            mem[BaseIdx + i] = ins;
        end
        mem[BaseIdx + n] = bad_funct ? 32'h0000_0008 : 32'hFC00_0000;
    endtask

    task automatic start_run(input bit first);
        rst_n = 1'b0;
        exp_q.delete();
        wait_left = 0;
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        rf[4] = 32'h0000_0800;
        for (int i = 0; i < 32; i++) ref_rf[i] = rf[i];
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        run_ref();
        @(negedge clk); #1;
        check("reset_pc", pc, ResetPc);
        check("reset_halt", {31'b0, halt}, 32'd0);
        check("reset_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("reset_rf_we", {31'b0, bus.rf_we}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, bus.mem_req}, 32'd1);
        check("first_addr", bus.mem_addr, ResetPc);
        if (first) begin
            for (int c = 0; c < 20 && pc == ResetPc; c++) @(negedge clk);
            #2;
            check("pc_after_fetch", pc, ResetPc + 32'd4);
        end
    endtask

    task automatic finish_run();
        for (int c = 0; c < 4000 && halt !== 1'b1; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
        check("halt_set", {31'b0, halt}, 32'd1);
        check("final_pc", pc, exp_end_pc);
        check("events_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("pc_frozen", pc, exp_end_pc);
    endtask

    // Memory responder: random wait states; random ack/rdata noise while idle.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (stall) begin
                bus.mem_ack = 1'b0;
            end else if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[11:2]];
                if (bus.mem_we) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
                wait_left = $urandom_range(0, max_wait);
            end else begin
                bus.mem_ack = 1'b0;
                wait_left--;
            end
        end else begin
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        #1;
        if (rst_n && bus.mem_req && bus.mem_ack) begin
            if (exp_q.size() == 0 || !exp_q[0].is_mem) begin
                n_checks++;
                n_errors++;
                $display("FAIL mem_event: unexpected transfer addr=%h we=%0d (t=%0t)",
                         bus.mem_addr, bus.mem_we, $time);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", bus.mem_addr, e.addr);
                check("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                if (e.we) check("mem_wdata", bus.mem_wdata, e.data);
            end
        end
        if (rst_n && bus.rf_we) begin
            if (exp_q.size() == 0 || exp_q[0].is_mem) begin
                n_checks++;
                n_errors++;
                $display("FAIL rf_event: unexpected write r%0d=%h (t=%0t)",
                         bus.rf_waddr, bus.rf_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("rf_waddr", {27'b0, bus.rf_waddr}, e.addr);
                check("rf_wdata", bus.rf_wdata, e.data);
            end
            if (bus.rf_waddr != 5'd0) rf[bus.rf_waddr] = bus.rf_wdata;
        end
    end

    initial begin
        for (int r = 0; r < 3; r++) begin
            max_wait = (r == 1) ? 0 : 3;
            load_program(40, r == 2);
            start_run(r == 0);
            finish_run();
        end

        // Misaligned store: sw $2, 2($4) with $4 = 0x800 must halt without a MEM request.
        max_wait = 0;
        load_program(0, 1'b0);
        mem[BaseIdx] = {6'h2B, 5'd4, 5'd2, 16'd2};
        start_run(1'b0);
        finish_run();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("halt_async_clear", {31'b0, halt}, 32'd0);

        // Reset mid-fetch must drop mem_req without waiting for a clock edge.
        stall = 1'b1;
        start_run(1'b0);
        repeat (3) @(negedge clk);
        #2;
        check("stalled_req", {31'b0, bus.mem_req}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("req_drop_on_reset", {31'b0, bus.mem_req}, 32'd0);
        check("pc_on_reset", pc, ResetPc);
        stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/z_exec_ctrl.md
Name: z_exec_ctrl

Overview:
- Multi-cycle MIPS-subset controller that drives the team's combinational ALU.
- Fetches instructions over a req/ack memory port and reads the register file.
- Presents operands and a synthesised R-type instruction word to the ALU, and writes results back.
- Owns the PC, branch resolution and load/store sequencing, which the ALU does not handle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ALIGN_CHECK, 1, if 1 a misaligned lw/sw address (addr[1:0]!=0) halts the core.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory transfer request
mem_we  out  1  1=write (sw), 0=read
mem_addr  out  32  byte address
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid when mem_ack=1
mem_ack  in  1  transfer completes on an edge where mem_req&mem_ack
rf_raddr1  out  5  rs
rf_raddr2  out  5  rt
rf_rdata1  in  32  combinational read of rf_raddr1
rf_rdata2  in  32  combinational read of rf_raddr2
rf_we  out  1  one-cycle write strobe
rf_waddr  out  5  write register
rf_wdata  out  32  write data
alu_ins  out  32  instruction word presented to ALU
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_shamt  out  5  ALU shift amount
alu_out  in  32  ALU result
alu_zero  in  1  ALU zero flag (ignored; zero is tested locally on alu_out)
pc  out  32  current PC
halt  out  1  sticky; set on illegal opcode, illegal funct or misalignment

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, IR/A/B/ALUOUT/MDR=0, halt=0. All strobes (mem_req, mem_we, rf_we) deassert immediately, including mid-transaction.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ack, then IR<=mem_rdata, pc<=pc+4, go to DECODE. Zero-wait ack (in the same cycle as req) is legal.
- DECODE: rf_raddr1=IR[25:21], rf_raddr2=IR[20:16]; A<=rf_rdata1, B<=rf_rdata2.
- DECODE legal opcodes: 000000 with funct in {100001, 100011, 101111, 000000, 000010}, 001001, 001100, 000100, 000101, 100011, 101011. Anything else goes to HALT.
- EXEC, R-type: alu_ins=IR, alu_a=A, alu_b=B, alu_shamt=IR[10:6]; ALUOUT<=alu_out; go to WB.
- EXEC, addiu/lw/sw: alu_ins=32'h0000_0021 (addu), alu_a=A, alu_b=sign-extend(IR[15:0]); ALUOUT<=alu_out. addiu goes to WB; lw/sw go to MEM.
- EXEC, misaligned lw/sw: if ALIGN_CHECK and alu_out[1:0]!=0, go to HALT instead of MEM.
- EXEC, andi: computed locally as A & zero-extend(IR[15:0]) into ALUOUT; go to WB.
- EXEC, beq/bne: alu_ins=32'h0000_0023 (subu), alu_a=A, alu_b=B.
  - Taken when (alu_out==0) for beq, (alu_out!=0) for bne.
  - If taken, pc<=pc+(sign-extend(IR[15:0])<<2), where pc is already pc+4.
  - Go to FETCH.
- Outside EXEC: alu_ins/alu_a/alu_b/alu_shamt driven to 0.
- MEM: mem_req=1, mem_addr=ALUOUT, mem_we=(op==sw), mem_wdata=B.
  - Hold req, address and data stable until ack.
  - On ack: lw does MDR<=mem_rdata and goes to WB; sw goes to FETCH.
- WB: rf_we=1 for exactly one cycle.
  - rf_waddr = IR[15:11] for R-type, IR[20:16] otherwise.
  - rf_wdata = MDR for lw, ALUOUT otherwise.
  - If rf_waddr==0, rf_we is forced to 0.
  - Go to FETCH.
- HALT: halt=1, all strobes 0, pc frozen; exit only by reset.
- mem_ack outside FETCH/MEM is ignored.
- All arithmetic is 32-bit modulo; no overflow traps.
- Cycle counts with zero-wait memory: R-type/addiu/andi 4, lw 5, sw 4, branch 3.

Test Plan:
1. Reset with RESET_PC=0x100, zero-wait memory -> first cycle after rst_n rise: mem_req=1, mem_addr=0x100; pc=0x104 after ack.
2. Fetch addiu $2,$1,-1 (0x2422FFFF) with $1=5 -> EXEC drives alu_ins=0x21, alu_b=0xFFFFFFFF; WB rf_waddr=2, rf_wdata=4, rf_we high exactly 1 cycle.
3. beq $1,$2,+3 at pc=0x40 with equal regs -> next fetch addr 0x50; with unequal regs -> 0x44; bne with equal regs -> 0x44.
4. lw $3,8($4) with $4=0x200, mem_ack delayed 3 cycles in MEM -> mem_addr=0x208 held stable 4 cycles; rf_wdata=mem_rdata, rf_waddr=3.
5. sw with effective address 0x202, ALIGN_CHECK=1 -> halt=1 after EXEC, no MEM request issued; pc frozen; rst_n low clears halt asynchronously.
6. addu writing $0, then opcode 0x3F -> rf_we stays 0 for the $0 write; halt asserts after DECODE of 0x3F; asserting rst_n low while mem_req=1 drops mem_req in the same cycle.
